extremity_switches_conditioner: RTL and testbench
=================================================

Name: extremity_switches_conditioner

Overview:
- Multi-channel successor of the single-motor extremity switch LED mapper.
- Per channel, takes two raw extremity switches and applies a 2-FF synchroniser, a per-switch debouncer, and a polarity correction.
- Maps the result to four front-panel LEDs (left/right, green/red) per channel, using the same per-LED-side selection codes.
- Generates the shared blink signal internally and exports the debounced, polarity-corrected switch states for the motor controller.

Parameters:
- NUM_CHANNELS, 16, number of motor channels (1..32).
- DEBOUNCE_CYCLES, 250000, consecutive clocks a new synchronised level must persist before being accepted; 0 = debouncer bypassed.
- BLINK_DIVIDER, 12500000, clocks per blink half-period (≥2).

Ports:
- ClkRs_ix  in  ckrs_t  clock/reset bundle: ClkRs_ix.clk is the single clock (25 MHz); ClkRs_ix.reset is asynchronous, active-high.
- rawswitches_i  in  [NUM_CHANNELS-1:0][1:0]  raw asynchronous switch inputs.
- switchesconfig_i  in  switchstate_t [NUM_CHANNELS-1:0][1:0]  per-switch Polarity and per-LED-side SelectedInputSwitches_b2.
- latch_clear_i  in  [NUM_CHANNELS-1:0]  one-cycle clear of latched reached flags.
- switches_o  out  [NUM_CHANNELS-1:0][1:0]  debounced, polarity-corrected switches.
- reached_o  out  [NUM_CHANNELS-1:0][1:0]  latched reached flags (feature-dependent).
- blinker_o  out  1  internal blink signal.
- led_lg_o, led_lr_o, led_rg_o, led_rr_o  out  [NUM_CHANNELS-1:0] each  LED drives.

Behaviour:
- Reset: all sync FFs, debounce counters, stable levels, blink counter, blinker_o, switches_o, reached_o and all LED outputs are 0. Reset is asynchronous assert; deassertion is sampled on clk.
- Synchroniser: q1 <= raw; q2 <= q1, per switch.
- Debouncer (DEBOUNCE_CYCLES=D>0), per switch, counter width $clog2(D+1):
  - If q2==stable: cnt <= 0.
  - Else if cnt==D-1: stable <= q2, cnt <= 0.
  - Else: cnt++.
  - Any return to stable before D consecutive differing cycles discards the pulse.
- D=0: stable <= q2 every cycle.
- corr = stable ^ Polarity. switches_o is registered from corr, so it updates one cycle after stable.
- Latency: if the raw level changes before edge 1, stable updates on edge 2+D, and the LEDs and switches_o update on edge 3+D.
- Blinker: counter 0..BLINK_DIVIDER-1. On wrap, blinker_o toggles and the counter returns to 0. Period = 2*BLINK_DIVIDER clocks.
- LED mapping: registered, evaluated every clock.
  - Left side uses switchesconfig_i[ch][1].SelectedInputSwitches_b2; right side uses [ch][0].
  - Left (lg, lr):
    - 00: lg = stable[1] (uncorrected), lr = blinker_o.
    - 01: lg = corr[0], lr = 0.
    - 10: lg = corr[1], lr = 0.
    - 11: lg = corr[0], lr = corr[1].
  - Right (rg, rr):
    - 00: rg = stable[0], rr = blinker_o.
    - 01/10/11: same as left with rg/rr.
- Config changes: Polarity and selection are not debounced. They take effect on the LED outputs and switches_o at the next edge.
- Channels are fully independent; identical config yields identical timing across channels.

Optional Feature:
- Macro: EXTREMITY_REACHED_LATCH_EN.
- Defined:
  - reached_o[ch][s] sets on a 0→1 transition of corr[ch][s], registered in the same cycle as switches_o.
  - It stays set until a latch_clear_i[ch] pulse, which clears both flags of that channel next edge.
  - Simultaneous set and clear: set wins.
  - A polarity flip that produces a 0→1 transition on corr also sets the flag.
- Undefined: reached_o tied to 0, latch_clear_i ignored, no latch logic synthesised.

Test Plan (NUM_CHANNELS=2, D=4, BLINK_DIVIDER=8):
- Reset release, all raw=0, cfg 00 on both sides → LEDs green=0. led_lr_o/led_rr_o follow blinker_o, which toggles every 8 clocks (period 16).
- ch0 cfg right=01, Polarity=0; raw[0][0] 0→1 held → switches_o[0][0] and led_rg_o[0] rise exactly on edge 7; led_rr_o[0]=0.
- Same setup, raw[0][0] pulses high for 3 clocks → no change on switches_o or LEDs. A 4-clock pulse → accepted, then released after 4 stable-low cycles.
- ch1 cfg both sides=11, Polarity[1][0]=1, raw=00 → lg=1, lr=0, rg=1, rr=0. Flip Polarity[1][0] to 0 → lg and rg fall on the next edge.
- EXTREMITY_REACHED_LATCH_EN defined:
  - raw[0][1] rises → reached_o[0][1]=1 persists after raw falls.
  - latch_clear_i[0] pulse → 0 next edge.
  - clear coincident with a new rise → stays 1.
- Assert reset mid-debounce (cnt=2) → all outputs 0 immediately. After release, the held input needs the full 2+D edges again.

Source files
------------

// File: rtl/extremity_switches_conditioner.sv
// Multi-channel extremity switch conditioner: per switch a 2-FF synchroniser,
// a debouncer and a polarity correction, then a per-channel map onto four
// front-panel LEDs. Also generates the shared blink signal.
//
// Ports:
//   ClkRs_ix          clock/reset bundle (clk, asynchronous active-high reset)
//   rawswitches_i     raw asynchronous switches, [channel][switch]
//   switchesconfig_i  per-switch Polarity and per-LED-side selection code
//   latch_clear_i     per-channel clear of the latched reached flags
//   switches_o        debounced, polarity-corrected switch states
//   reached_o         latched reached flags (0 unless the latch is built)
//   blinker_o         shared blink signal, period 2*BLINK_DIVIDER clocks
//   led_lg_o/led_lr_o left green/red LED drives per channel
//   led_rg_o/led_rr_o right green/red LED drives per channel
//
// Build option: define EXTREMITY_REACHED_LATCH_EN to build the reached-flag
// latch; otherwise reached_o is tied to 0 and latch_clear_i is ignored.

package extremity_switches_conditioner_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef struct packed {
        logic       Polarity;
        logic [1:0] SelectedInputSwitches_b2;
    } switchstate_t;
endpackage

module extremity_switches_conditioner
    import extremity_switches_conditioner_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BLINK_DIVIDER   = 12500000
) (
    input  ckrs_t                              ClkRs_ix,
    input  logic         [NUM_CHANNELS-1:0][1:0] rawswitches_i,
    input  switchstate_t [NUM_CHANNELS-1:0][1:0] switchesconfig_i,
    input  logic         [NUM_CHANNELS-1:0]      latch_clear_i,
    output logic         [NUM_CHANNELS-1:0][1:0] switches_o,
    output logic         [NUM_CHANNELS-1:0][1:0] reached_o,
    output logic                                 blinker_o,
    output logic         [NUM_CHANNELS-1:0]      led_lg_o,
    output logic         [NUM_CHANNELS-1:0]      led_lr_o,
    output logic         [NUM_CHANNELS-1:0]      led_rg_o,
    output logic         [NUM_CHANNELS-1:0]      led_rr_o
);

    localparam int unsigned BLK_W = (BLINK_DIVIDER > 2) ? $clog2(BLINK_DIVIDER) : 1;

    logic clk;
    logic rst;
    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    logic [NUM_CHANNELS-1:0][1:0] sync1_q, sync2_q, stable_q;
    logic [NUM_CHANNELS-1:0][1:0] corr_c, switches_q;
    logic [NUM_CHANNELS-1:0]      lg_d, lr_d, rg_d, rr_d;
    logic [NUM_CHANNELS-1:0]      lg_q, lr_q, rg_q, rr_q;
    logic [BLK_W-1:0]             blk_cnt_q, blk_cnt_d;
    logic                         blinker_q, blinker_d;

    // Two-flop synchroniser on every raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawswitches_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-switch debouncer
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        for (genvar s = 0; s < 2; s++) begin : g_sw
            if (DEBOUNCE_CYCLES == 0) begin : g_bypass
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stable_q[ch][s] <= 1'b0;
                    else     stable_q[ch][s] <= sync2_q[ch][s];
                end
            end else begin : g_deb
                localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
                logic [CNT_W-1:0] cnt_q, cnt_d;
                logic             stable_d;

                // A level is accepted only after D consecutive differing samples
                always_comb begin
                    cnt_d    = '0;
                    stable_d = stable_q[ch][s];
                    if (sync2_q[ch][s] == stable_q[ch][s]) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable_d = sync2_q[ch][s];
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt_q           <= '0;
                        stable_q[ch][s] <= 1'b0;
                    end else begin
                        cnt_q           <= cnt_d;
                        stable_q[ch][s] <= stable_d;
                    end
                end
            end
        end
    end

    // Blink generator: toggle every BLINK_DIVIDER clocks
    always_comb begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
        blinker_d = blinker_q;
        if (blk_cnt_q == BLK_W'(BLINK_DIVIDER - 1)) begin
            blk_cnt_d = '0;
            blinker_d = ~blinker_q;
        end
    end

    // Polarity correction and LED selection; config acts without debouncing
    always_comb begin
        corr_c = '0;
        lg_d   = '0;
        lr_d   = '0;
        rg_d   = '0;
        rr_d   = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int s = 0; s < 2; s++) begin
                corr_c[ch][s] = stable_q[ch][s] ^ switchesconfig_i[ch][s].Polarity;
            end
            case (switchesconfig_i[ch][1].SelectedInputSwitches_b2)
                2'b00: begin
                    lg_d[ch] = stable_q[ch][1];
                    lr_d[ch] = blinker_q;
                end
                2'b01: lg_d[ch] = corr_c[ch][0];
                2'b10: lg_d[ch] = corr_c[ch][1];
                default: begin
                    lg_d[ch] = corr_c[ch][0];
                    lr_d[ch] = corr_c[ch][1];
                end
            endcase
            case (switchesconfig_i[ch][0].SelectedInputSwitches_b2)
                2'b00: begin
                    rg_d[ch] = stable_q[ch][0];
                    rr_d[ch] = blinker_q;
                end
                2'b01: rg_d[ch] = corr_c[ch][0];
                2'b10: rg_d[ch] = corr_c[ch][1];
                default: begin
                    rg_d[ch] = corr_c[ch][0];
                    rr_d[ch] = corr_c[ch][1];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q  <= '0;
            blinker_q  <= 1'b0;
            switches_q <= '0;
            lg_q       <= '0;
            lr_q       <= '0;
            rg_q       <= '0;
            rr_q       <= '0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            blinker_q  <= blinker_d;
            switches_q <= corr_c;
            lg_q       <= lg_d;
            lr_q       <= lr_d;
            rg_q       <= rg_d;
            rr_q       <= rr_d;
        end
    end

`ifdef EXTREMITY_REACHED_LATCH_EN
    logic [NUM_CHANNELS-1:0][1:0] reached_q, reached_d;

    // Rising corrected level sets the flag; a set beats a coincident clear
    always_comb begin
        reached_d = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            reached_d[ch] = (latch_clear_i[ch] ? 2'b00 : reached_q[ch])
                          | (corr_c[ch] & ~switches_q[ch]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) reached_q <= '0;
        else     reached_q <= reached_d;
    end

    assign reached_o = reached_q;
`else
    logic unused_latch_clear;
    assign unused_latch_clear = ^latch_clear_i;
    assign reached_o          = '0;
`endif

    assign switches_o = switches_q;
    assign blinker_o  = blinker_q;
    assign led_lg_o   = lg_q;
    assign led_lr_o   = lr_q;
    assign led_rg_o   = rg_q;
    assign led_rr_o   = rr_q;

endmodule

// File: tb/tb_extremity_switches_conditioner.sv
// Bench for extremity_switches_conditioner (2 channels, D=4, blink divider 8).
// A behavioural model pushes the expected outputs of every clock edge into a
// queue; they are popped and compared on the following falling edge.
module tb_extremity_switches_conditioner;
    import extremity_switches_conditioner_pkg::*;

    localparam int NC = 2;
    localparam int DB = 4;
    localparam int BD = 8;
`ifdef EXTREMITY_REACHED_LATCH_EN
    localparam logic EXP_LATCH = 1'b1;
`else
    localparam logic EXP_LATCH = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] sw;
        logic [3:0] rch;
        logic [1:0] lg;
        logic [1:0] lr;
        logic [1:0] rg;
        logic [1:0] rr;
        logic       blink;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ckrs_t ck;
    logic         [NC-1:0][1:0] raw = '0;
    switchstate_t [NC-1:0][1:0] cfg = '0;
    logic         [NC-1:0]      clr = '0;
    logic         [NC-1:0][1:0] switches_o, reached_o;
    logic                       blinker_o;
    logic         [NC-1:0]      led_lg_o, led_lr_o, led_rg_o, led_rr_o;

    assign ck = {clk, rst};
    always #5 clk = ~clk;

    extremity_switches_conditioner #(
        .NUM_CHANNELS   (NC),
        .DEBOUNCE_CYCLES(DB),
        .BLINK_DIVIDER  (BD)
    ) dut (
        .ClkRs_ix        (ck),
        .rawswitches_i   (raw),
        .switchesconfig_i(cfg),
        .latch_clear_i   (clr),
        .switches_o      (switches_o),
        .reached_o       (reached_o),
        .blinker_o       (blinker_o),
        .led_lg_o        (led_lg_o),
        .led_lr_o        (led_lr_o),
        .led_rg_o        (led_rg_o),
        .led_rr_o        (led_rr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Behavioural reference model
    exp_t sb[$];
    logic [NC-1:0][1:0] m_q1 = '0, m_q2 = '0, m_stab = '0, m_sw = '0, m_rch = '0;
    int   m_run[NC][2];
    logic m_blink = 1'b0;
    int   m_bcnt  = 0;

    always @(posedge clk or posedge rst) begin
        exp_t       e;
        logic [1:0] corr;
        if (rst) begin
            m_q1 = '0; m_q2 = '0; m_stab = '0; m_sw = '0; m_rch = '0;
            m_blink = 1'b0; m_bcnt = 0;
            for (int ch = 0; ch < NC; ch++) begin
                m_run[ch][0] = 0;
                m_run[ch][1] = 0;
            end
            sb.delete();
        end else begin
            e = '0;
            for (int ch = 0; ch < NC; ch++) begin
                corr = m_stab[ch] ^ {cfg[ch][1].Polarity, cfg[ch][0].Polarity};
                case (cfg[ch][1].SelectedInputSwitches_b2)
                    2'd0: begin e.lg[ch] = m_stab[ch][1]; e.lr[ch] = m_blink; end
                    2'd1: e.lg[ch] = corr[0];
                    2'd2: e.lg[ch] = corr[1];
                    default: begin e.lg[ch] = corr[0]; e.lr[ch] = corr[1]; end
                endcase
                case (cfg[ch][0].SelectedInputSwitches_b2)
                    2'd0: begin e.rg[ch] = m_stab[ch][0]; e.rr[ch] = m_blink; end
                    2'd1: e.rg[ch] = corr[0];
                    2'd2: e.rg[ch] = corr[1];
                    default: begin e.rg[ch] = corr[0]; e.rr[ch] = corr[1]; end
                endcase
`ifdef EXTREMITY_REACHED_LATCH_EN
                if (clr[ch]) m_rch[ch] = 2'b00;
                m_rch[ch] = m_rch[ch] | (corr & ~m_sw[ch]);
`endif
                m_sw[ch] = corr;
                for (int s = 0; s < 2; s++) begin
                    if (m_q2[ch][s] != m_stab[ch][s]) begin
                        m_run[ch][s]++;
                        if (m_run[ch][s] == DB) begin
                            m_stab[ch][s] = m_q2[ch][s];
                            m_run[ch][s]  = 0;
                        end
                    end else begin
                        m_run[ch][s] = 0;
                    end
                end
            end
            m_q2 = m_q1;
            m_q1 = raw;
            m_bcnt++;
            if (m_bcnt == BD) begin
                m_blink = ~m_blink;
                m_bcnt  = 0;
            end
            e.sw    = m_sw;
            e.rch   = m_rch;
            e.blink = m_blink;
            sb.push_back(e);
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("sb_switches", 32'(switches_o), 32'(e.sw));
            check_val("sb_reached",  32'(reached_o),  32'(e.rch));
            check_val("sb_blinker",  32'(blinker_o),  32'(e.blink));
            check_val("sb_led_lg",   32'(led_lg_o),   32'(e.lg));
            check_val("sb_led_lr",   32'(led_lr_o),   32'(e.lr));
            check_val("sb_led_rg",   32'(led_rg_o),   32'(e.rg));
            check_val("sb_led_rr",   32'(led_rr_o),   32'(e.rr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_sw"},    32'(switches_o), 32'd0);
        check_val({tag, "_rch"},   32'(reached_o),  32'd0);
        check_val({tag, "_blink"}, 32'(blinker_o),  32'd0);
        check_val({tag, "_leds"},  32'({led_lg_o, led_lr_o, led_rg_o, led_rr_o}), 32'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;

        // Blinker toggles after 8 edges; red LEDs follow it in cfg 00
        tick(7);
        check_val("blink_e7", 32'(blinker_o), 32'd0);
        tick(1);
        check_val("blink_e8", 32'(blinker_o), 32'd1);
        tick(30);

        // Held rise on ch0 right switch: visible exactly on edge 7
        cfg[0][0].SelectedInputSwitches_b2 = 2'b01;
        tick(2);
        raw[0][0] = 1'b1;
        tick(6);
        check_val("rise_e6_sw", 32'(switches_o[0][0]), 32'd0);
        check_val("rise_e6_rg", 32'(led_rg_o[0]),      32'd0);
        tick(1);
        check_val("rise_e7_sw", 32'(switches_o[0][0]), 32'd1);
        check_val("rise_e7_rg", 32'(led_rg_o[0]),      32'd1);
        check_val("rise_e7_rr", 32'(led_rr_o[0]),      32'd0);
        tick(10);
        raw[0][0] = 1'b0;
        tick(12);

        // 3-clock glitch rejected, 4-clock pulse accepted and later released
        raw[0][0] = 1'b1;
        tick(3);
        raw[0][0] = 1'b0;
        tick(10);
        check_val("glitch3_sw", 32'(switches_o[0][0]), 32'd0);
        raw[0][0] = 1'b1;
        tick(4);
        raw[0][0] = 1'b0;
        tick(3);
        check_val("pulse4_e7",  32'(switches_o[0][0]), 32'd1);
        tick(3);
        check_val("pulse4_e10", 32'(switches_o[0][0]), 32'd1);
        tick(1);
        check_val("pulse4_e11", 32'(switches_o[0][0]), 32'd0);
        tick(4);

        // ch1 both sides code 11, inverted right switch
        cfg[1][0].Polarity = 1'b1;
        cfg[1][0].SelectedInputSwitches_b2 = 2'b11;
        cfg[1][1].SelectedInputSwitches_b2 = 2'b11;
        tick(2);
        check_val("pol_lg", 32'(led_lg_o[1]), 32'd1);
        check_val("pol_lr", 32'(led_lr_o[1]), 32'd0);
        check_val("pol_rg", 32'(led_rg_o[1]), 32'd1);
        check_val("pol_rr", 32'(led_rr_o[1]), 32'd0);
        cfg[1][0].Polarity = 1'b0;
        tick(1);
        check_val("polflip_lg", 32'(led_lg_o[1]), 32'd0);
        check_val("polflip_rg", 32'(led_rg_o[1]), 32'd0);
        tick(3);

        // Reached latch: set, hold, clear, set-beats-clear
        raw[0][1] = 1'b1;
        tick(10);
        check_val("latch_set", 32'(reached_o[0][1]), 32'(EXP_LATCH));
        raw[0][1] = 1'b0;
        tick(10);
        check_val("latch_hold", 32'(reached_o[0][1]), 32'(EXP_LATCH));
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        check_val("latch_clr", 32'(reached_o[0][1]), 32'd0);
        tick(2);
        raw[0][1] = 1'b1;
        tick(6);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        check_val("latch_set_wins", 32'(reached_o[0][1]), 32'(EXP_LATCH));
        raw[0][1] = 1'b0;
        tick(10);

        // Reset in the middle of a debounce run
        raw[0][1] = 1'b1;
        tick(4);
        #1 rst = 1'b1;
        #1 check_all_zero("midrst");
        tick(3);
        rst = 1'b0;
        tick(6);
        check_val("postrst_e6", 32'(switches_o[0][1]), 32'd0);
        tick(1);
        check_val("postrst_e7", 32'(switches_o[0][1]), 32'd1);
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
